dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller for the MIPS pipeline's MEM stage.
- Upstream: consumes the CPU data request (cpu_req_typeD).
- Downstream: drives the memory request (mem_req_typeD) and consumes the memory line result (mem_result_type).
- Returns cpu_result_type to the pipeline.
- Geometry: 16 lines × 128-bit, 24-bit tag. Address split: tag [31:8], index [7:4], word [3:2]; bits [1:0] ignored.

Parameters:
- None. Geometry is fixed by the cache_def package types.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_addr  in  32  byte address.
- cpu_req_data  in  32  store data.
- cpu_req_rw  in  1  1 = write, 0 = read.
- cpu_req_valid  in  1  request present; held stable until cpu_res_ready.
- cpu_res_data  out  32  load data; valid only while cpu_res_ready = 1.
- cpu_res_ready  out  1  one-cycle completion pulse.
- mem_req_addr  out  32  line-aligned address; [3:0] = 0.
- mem_req_data  out  128  victim line on write-back.
- mem_req_rw  out  1  1 = write-back, 0 = fill.
- mem_req_valid  out  1  memory request; held until mem_res_ready.
- mem_res_data  in  128  fill line.
- mem_res_ready  in  1  one-cycle memory completion.

Behaviour:
- Reset (async, any state):
  - State returns to IDLE.
  - All valid and dirty bits clear. Data and tag contents are not reset.
  - All outputs 0.
- IDLE: if cpu_req_valid, go to COMPARE next cycle. No outputs asserted.
- COMPARE: hit = valid[index] && tag[index] == addr[31:8].
  - Hit, read: cpu_res_ready = 1; cpu_res_data = line word[addr[3:2]]; go to IDLE.
  - Hit, write: merge cpu_req_data into word[addr[3:2]]; set dirty; cpu_res_ready = 1; go to IDLE.
  - Miss, line clean or invalid: go to ALLOCATE.
  - Miss, line valid and dirty: go to WRITEBACK.
  - Hit latency: 2 cycles from the valid-sampled edge to the ready pulse.
- WRITEBACK:
  - Drive mem_req_valid = 1, mem_req_rw = 1, mem_req_addr = {old_tag, index, 4'b0}, mem_req_data = old line.
  - On mem_res_ready: go to ALLOCATE.
- ALLOCATE:
  - Drive mem_req_valid = 1, mem_req_rw = 0, mem_req_addr = {addr[31:4], 4'b0}.
  - On mem_res_ready: write mem_res_data to the line; tag = addr[31:8]; valid = 1; dirty = 0; go to COMPARE.
  - The re-compare then hits and completes the read or write.
- mem_req_valid drops the cycle after mem_res_ready is sampled.
- mem_res_ready outside WRITEBACK/ALLOCATE is ignored.
- cpu_req_valid deasserting mid-miss is a protocol violation. The FSM completes the miss anyway; no ready pulse is produced if valid is low in COMPARE.
- Back-to-back requests: the earliest new acceptance is IDLE in the cycle after the ready pulse, so the minimum spacing is 2 cycles.
- Stores never write through. Memory is updated only on dirty eviction.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs stat_hits [31:0] and stat_misses [31:0].
  - Increment in COMPARE on the first compare of a request: hit → hits, miss → misses.
  - The post-allocate re-compare is not counted.
  - Both cleared by rst; wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add to the cache_def package: cache_state_type enum {IDLE, COMPARE, ALLOCATE, WRITEBACK}, and constants TAG_MSB = 31, TAG_LSB = 8, IDX_MSB = 7, IDX_LSB = 4.
- Sub-module dcache_mem: 16-entry tag array (tag_type) plus data array (cache_data_type).
  - Combinational read, written on the clk edge when cache_req_type.we = 1.
  - Async rst clears valid and dirty bits.
- The FSM stays in dcache_ctrl.

Test Plan:
- Cold read of 0x0000_0104; memory returns line 0x4444_3333_2222_1111… → ALLOCATE, mem addr 0x0000_0100, rw = 0; then ready with data = word1 (0x2222…).
- Read 0x0000_0108 after the above → hit; ready 2 cycles after valid; no mem_req_valid; data = word2.
- Write 0xDEAD_BEEF to 0x0000_0100, then read it back → both hit; readback 0xDEADBEEF; dirty[0] = 1.
- Read 0x0001_0100 (same index 0, new tag) → WRITEBACK first: addr 0x0000_0100, rw = 1, data word0 = 0xDEADBEEF; then ALLOCATE addr 0x0001_0100.
- Hold mem_res_ready low for 20 cycles in ALLOCATE → mem_req fields stable, no ready; complete normally after.
- Assert rst mid-WRITEBACK → mem_req_valid = 0 immediately; state IDLE; a later read of 0x0000_0100 misses (valid cleared).

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// cache_def: shared types and constants for the direct-mapped data cache.
// Holds CPU/memory request bundles, tag/data array types and the FSM state enum.
package cache_def;

    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 8;
    localparam int IDX_MSB = 7;
    localparam int IDX_LSB = 4;

    localparam int TAG_W  = TAG_MSB - TAG_LSB + 1;
    localparam int IDX_W  = IDX_MSB - IDX_LSB + 1;
    localparam int LINES  = 1 << IDX_W;
    localparam int LINE_W = 128;

    typedef logic [TAG_W-1:0]  tag_bits_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic      valid;
        logic      dirty;
        tag_bits_t tag;
    } tag_type;

    typedef struct packed {
        idx_t index;
        logic we;
    } cache_req_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_typeD;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]    addr;
        cache_data_type data;
        logic           rw;
        logic           valid;
    } mem_req_typeD;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_result_type;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        ALLOCATE,
        WRITEBACK
    } cache_state_type;

    function automatic logic [31:0] get_word(
        input cache_data_type line,
        input logic [1:0]     w
    );
        return line[32*w +: 32];
    endfunction

    function automatic cache_data_type put_word(
        input cache_data_type line,
        input logic [1:0]     w,
        input logic [31:0]    d
    );
        cache_data_type r;
        r = line;
        r[32*w +: 32] = d;
        return r;
    endfunction

endpackage

// File: rtl/dcache_mem.sv
// dcache_mem: 16-entry tag array plus 128-bit data array, combinational read.
// Ports: clk, rst (async, clears valid/dirty), req (index/we), tag/data write, tag/data read.
module dcache_mem
    import cache_def::*;
(
    input  logic           clk,
    input  logic           rst,
    input  cache_req_type  req,
    input  tag_type        tag_write,
    input  cache_data_type data_write,
    output tag_type        tag_read,
    output cache_data_type data_read
);

    logic [LINES-1:0] valid_bits;
    logic [LINES-1:0] dirty_bits;
    tag_bits_t        tags  [LINES];
    cache_data_type   lines [LINES];

    // Only the status bits are reset; tag and data storage is left as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (req.we) begin
            valid_bits[req.index] <= tag_write.valid;
            dirty_bits[req.index] <= tag_write.dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (req.we) begin
            tags[req.index]  <= tag_write.tag;
            lines[req.index] <= data_write;
        end
    end

    assign tag_read.valid = valid_bits[req.index];
    assign tag_read.dirty = dirty_bits[req.index];
    assign tag_read.tag   = tags[req.index];
    assign data_read      = lines[req.index];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate D-cache controller (MEM stage).
// Ports: clk, rst (async high); cpu_req_* in / cpu_res_* out; mem_req_* out / mem_res_* in.
// Optional DCACHE_STATS_EN adds stat_hits/stat_misses counters of first compares.
module dcache_ctrl
    import cache_def::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  cpu_req_addr,
    input  logic [31:0]  cpu_req_data,
    input  logic         cpu_req_rw,
    input  logic         cpu_req_valid,
    output logic [31:0]  cpu_res_data,
    output logic         cpu_res_ready,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    output logic         mem_req_rw,
    output logic         mem_req_valid,
    input  logic [127:0] mem_res_data,
    input  logic         mem_res_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
`endif
);

    cpu_req_typeD    cpu_req;
    mem_result_type  mem_res;
    cpu_result_type  res;
    mem_req_typeD    mreq;
    cache_state_type state;

    cache_req_type   arr_req;
    tag_type         tag_read;
    tag_type         tag_write;
    cache_data_type  data_read;
    cache_data_type  data_write;

    tag_bits_t       req_tag;
    idx_t            req_idx;
    logic [1:0]      req_word;
    logic            hit;
    logic            unused_bits;

    assign cpu_req = '{
        addr:  cpu_req_addr,
        data:  cpu_req_data,
        rw:    cpu_req_rw,
        valid: cpu_req_valid
    };
    assign mem_res = '{data: mem_res_data, ready: mem_res_ready};

    assign req_tag     = cpu_req.addr[TAG_MSB:TAG_LSB];
    assign req_idx     = cpu_req.addr[IDX_MSB:IDX_LSB];
    assign req_word    = cpu_req.addr[3:2];
    assign unused_bits = ^cpu_req.addr[1:0];

    assign hit = tag_read.valid && (tag_read.tag == req_tag);

    // Array writes: store-hit merge in COMPARE, line fill at the end of ALLOCATE.
    always_comb begin
        arr_req.index = req_idx;
        arr_req.we    = 1'b0;
        tag_write     = tag_read;
        data_write    = data_read;
        if (state == COMPARE && cpu_req.valid && hit && cpu_req.rw) begin
            arr_req.we      = 1'b1;
            tag_write.dirty = 1'b1;
            data_write      = put_word(data_read, req_word, cpu_req.data);
        end else if (state == ALLOCATE && mreq.valid && mem_res.ready) begin
            arr_req.we = 1'b1;
            tag_write  = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
            data_write = mem_res.data;
        end
    end

    dcache_mem u_mem (
        .clk        (clk),
        .rst        (rst),
        .req        (arr_req),
        .tag_write  (tag_write),
        .data_write (data_write),
        .tag_read   (tag_read),
        .data_read  (data_read)
    );

`ifdef DCACHE_STATS_EN
    logic first_cmp;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            res   <= '0;
            mreq  <= '0;
`ifdef DCACHE_STATS_EN
            first_cmp   <= 1'b0;
            stat_hits   <= '0;
            stat_misses <= '0;
`endif
        end else begin
            res <= '0;
            case (state)
                // A request still held during its own ready pulse is not re-accepted.
                IDLE: begin
                    if (cpu_req.valid && !res.ready) begin
                        state <= COMPARE;
`ifdef DCACHE_STATS_EN
                        first_cmp <= 1'b1;
`endif
                    end
                end
                COMPARE: begin
`ifdef DCACHE_STATS_EN
                    first_cmp <= 1'b0;
                    if (first_cmp && cpu_req.valid) begin
                        if (hit) stat_hits   <= stat_hits + 32'd1;
                        else     stat_misses <= stat_misses + 32'd1;
                    end
`endif
                    if (!cpu_req.valid) begin
                        state <= IDLE;
                    end else if (hit) begin
                        res.ready <= 1'b1;
                        if (!cpu_req.rw) res.data <= get_word(data_read, req_word);
                        state <= IDLE;
                    end else if (tag_read.valid && tag_read.dirty) begin
                        mreq <= '{
                            addr:  {tag_read.tag, req_idx, 4'b0},
                            data:  data_read,
                            rw:    1'b1,
                            valid: 1'b1
                        };
                        state <= WRITEBACK;
                    end else begin
                        mreq <= '{
                            addr:  {cpu_req.addr[31:4], 4'b0},
                            data:  '0,
                            rw:    1'b0,
                            valid: 1'b1
                        };
                        state <= ALLOCATE;
                    end
                end
                // Valid drops for one cycle between write-back and fill.
                WRITEBACK: begin
                    if (mem_res.ready) begin
                        mreq.valid <= 1'b0;
                        state      <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (!mreq.valid) begin
                        mreq <= '{
                            addr:  {cpu_req.addr[31:4], 4'b0},
                            data:  '0,
                            rw:    1'b0,
                            valid: 1'b1
                        };
                    end else if (mem_res.ready) begin
                        mreq.valid <= 1'b0;
                        state      <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_res_data  = res.data;
    assign cpu_res_ready = res.ready;
    assign mem_req_addr  = mreq.addr;
    assign mem_req_data  = mreq.data;
    assign mem_req_rw    = mreq.rw;
    assign mem_req_valid = mreq.valid;

endmodule
